dcache_load_port_driver: RTL and testbench

- Converts a simple valid/ready load-command stream into the CVA6 two-phase D$ request protocol (index/grant, then tag, then rvalid) on one dcache_req port of the cache subsystem.
- Sits directly upstream of the cache-only CVA6 top in the std-cache unit bench, in place of the load unit.
- Returns the aligned, sign/zero-extended load result on a valid/ready response stream.
- Handles kill and response timeout.

---
 rtl/dcache_load_port_driver.sv | 171 +++++++++++++++++
 tb/tb_dcache_load_port_driver.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_load_port_driver.sv
// Turns a valid/ready load-command stream into the two-phase D$ request protocol
// (index/grant, tag, rvalid) and returns aligned, extended load data on a response stream.
module dcache_load_port_driver #(
  parameter int IndexWidth    = 12,
  parameter int TagWidth      = 44,
  parameter int DataWidth     = 64,
  parameter int TimeoutCycles = 256,
  localparam int PAddrWidth   = IndexWidth + TagWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [PAddrWidth-1:0] cmd_paddr_i,
  input  logic [1:0]            cmd_size_i,
  input  logic                  cmd_signed_i,
  input  logic                  kill_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [63:0]           rsp_data_o,
  output logic                  rsp_err_o,
  output logic [IndexWidth-1:0] dreq_address_index_o,
  output logic [TagWidth-1:0]   dreq_address_tag_o,
  output logic                  dreq_data_req_o,
  output logic [7:0]            dreq_data_be_o,
  output logic [1:0]            dreq_data_size_o,
  output logic                  dreq_tag_valid_o,
  output logic                  dreq_kill_req_o,
  output logic                  dreq_data_we_o,
  output logic [DataWidth-1:0]  dreq_data_wdata_o,
  input  logic                  dreq_data_gnt_i,
  input  logic                  dreq_data_rvalid_i,
  input  logic [DataWidth-1:0]  dreq_data_rdata_i,
  output logic [2:0]            dbg_state_o
);

  // Handshakes: a cmd beat transfers on a clock edge where cmd_valid_i && cmd_ready_o,
  // a rsp beat where rsp_valid_o && rsp_ready_i; valid never drops before its transfer.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_TAG      = 3'd2,
    S_WAIT     = 3'd3,
    S_KILLWAIT = 3'd4,
    S_RESP     = 3'd5
  } state_e;

  localparam int CntWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  state_e                state_q;
  logic [PAddrWidth-1:0] paddr_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [63:0]           rsp_data_q;
  logic                  rsp_err_q;

  logic [63:0] shifted;
  logic [63:0] aligned;
  logic [7:0]  be;
  logic        timeout;

  always_comb begin
    shifted = dreq_data_rdata_i >> {paddr_q[2:0], 3'b000};
    aligned = '0;
    be      = '0;
    case (size_q)
      2'd0: begin
        aligned = {{56{signed_q & shifted[7]}}, shifted[7:0]};
        be      = 8'h01 << paddr_q[2:0];
      end
      2'd1: begin
        aligned = {{48{signed_q & shifted[15]}}, shifted[15:0]};
        be      = 8'h03 << paddr_q[2:0];
      end
      2'd2: begin
        aligned = {{32{signed_q & shifted[31]}}, shifted[31:0]};
        be      = 8'h0F << paddr_q[2:0];
      end
      default: begin
        aligned = shifted;
        be      = 8'hFF << paddr_q[2:0];
      end
    endcase
  end

  // The TAG cycle plus TimeoutCycles-1 WAIT cycles put the error response
  // exactly TimeoutCycles cycles after the tag phase.
  assign timeout = (cnt_q == CntWidth'(TimeoutCycles - 2));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      paddr_q    <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            paddr_q  <= cmd_paddr_i;
            size_q   <= cmd_size_i;
            signed_q <= cmd_signed_i;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          if (dreq_data_gnt_i) state_q <= S_TAG;
        end
        S_TAG: begin
          if (kill_i) begin
            state_q <= S_KILLWAIT;
          end else if (dreq_data_rvalid_i) begin
            rsp_data_q <= aligned;
            rsp_err_q  <= 1'b0;
            state_q    <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dreq_data_rvalid_i) begin
            rsp_data_q <= aligned;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
            state_q    <= S_RESP;
          end else if (timeout) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
        end
        S_KILLWAIT: begin
          // The rvalid here is the cache acknowledging the kill; it carries no data.
          if (dreq_data_rvalid_i || timeout) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o          = (state_q == S_IDLE);
  assign rsp_valid_o          = (state_q == S_RESP);
  assign rsp_data_o           = rsp_data_q;
  assign rsp_err_o            = rsp_err_q;
  assign dreq_data_req_o      = (state_q == S_REQ);
  assign dreq_address_index_o = dreq_data_req_o ? paddr_q[IndexWidth-1:0] : '0;
  assign dreq_data_be_o       = dreq_data_req_o ? be : '0;
  assign dreq_data_size_o     = dreq_data_req_o ? size_q : '0;
  assign dreq_tag_valid_o     = (state_q == S_TAG) && !kill_i;
  assign dreq_kill_req_o      = (state_q == S_TAG) && kill_i;
  assign dreq_address_tag_o   = dreq_tag_valid_o ? paddr_q[PAddrWidth-1:IndexWidth] : '0;
  assign dreq_data_we_o       = 1'b0;
  assign dreq_data_wdata_o    = '0;
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_dcache_load_port_driver.sv
// Bench for dcache_load_port_driver: directed test-plan cases plus randomized loads,
// with a queue-based scoreboard checked by an independent response monitor.
module tb_dcache_load_port_driver;

  localparam int IW = 12;
  localparam int TW = 44;
  localparam int PW = IW + TW;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [PW-1:0] cmd_paddr_i = '0;
  logic [1:0]    cmd_size_i = '0;
  logic          cmd_signed_i = 1'b0;
  logic          kill_i = 1'b0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [63:0]   rsp_data_o;
  logic          rsp_err_o;
  logic [IW-1:0] dreq_address_index_o;
  logic [TW-1:0] dreq_address_tag_o;
  logic          dreq_data_req_o;
  logic [7:0]    dreq_data_be_o;
  logic [1:0]    dreq_data_size_o;
  logic          dreq_tag_valid_o;
  logic          dreq_kill_req_o;
  logic          dreq_data_we_o;
  logic [63:0]   dreq_data_wdata_o;
  logic          dreq_data_gnt_i = 1'b0;
  logic          dreq_data_rvalid_i = 1'b0;
  logic [63:0]   dreq_data_rdata_i = '0;
  logic [2:0]    dbg_state_o;

  dcache_load_port_driver #(
    .IndexWidth(IW), .TagWidth(TW), .DataWidth(64), .TimeoutCycles(T)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_paddr_i(cmd_paddr_i),
    .cmd_size_i(cmd_size_i), .cmd_signed_i(cmd_signed_i), .kill_i(kill_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o),
    .dreq_address_index_o(dreq_address_index_o), .dreq_address_tag_o(dreq_address_tag_o),
    .dreq_data_req_o(dreq_data_req_o), .dreq_data_be_o(dreq_data_be_o),
    .dreq_data_size_o(dreq_data_size_o), .dreq_tag_valid_o(dreq_tag_valid_o),
    .dreq_kill_req_o(dreq_kill_req_o), .dreq_data_we_o(dreq_data_we_o),
    .dreq_data_wdata_o(dreq_data_wdata_o), .dreq_data_gnt_i(dreq_data_gnt_i),
    .dreq_data_rvalid_i(dreq_data_rvalid_i), .dreq_data_rdata_i(dreq_data_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [80:0] exp_q[$];   // {data[63:0], err, latency[15:0]}
  int n_checks = 0;
  int n_fail   = 0;
  int tag_cyc  = 0;
  int bp_hold  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_align(input logic [63:0] rdata, input logic [2:0] off,
                                            input logic [1:0] size, input logic sgn);
    int          bits;
    logic [63:0] sh;
    logic [63:0] mask;
    logic [63:0] v;
    bits = 8 << size;
    sh   = rdata >> (8 * off);
    mask = (bits == 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
    v    = sh & mask;
    if (sgn && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] ref_be(input logic [2:0] off, input logic [1:0] size);
    int m;
    m = ((1 << (1 << size)) - 1) << off;
    return 8'(m & 255);
  endfunction

  // ---------------- response backpressure ----------------
  always @(posedge clk) begin
    #1;
    if (bp_hold > 0) begin
      rsp_ready_i = 1'b0;
      if (rsp_valid_o) bp_hold--;
    end else begin
      rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  logic        mon_active = 1'b0;
  logic [63:0] mon_data;
  logic        mon_err;
  logic [80:0] mon_e;

  always @(negedge clk) begin
    if (rst_i) begin
      mon_active = 1'b0;
    end else if (rsp_valid_o) begin
      check("cmd_ready_low_in_resp", cmd_ready_o, 0);
      if (!mon_active) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp_valid", rsp_valid_o, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_data", rsp_data_o, mon_e[80:17]);
          check("rsp_err", rsp_err_o, mon_e[16]);
          check("rsp_latency", cyc - tag_cyc, mon_e[15:0]);
        end
        mon_data   = rsp_data_o;
        mon_err    = rsp_err_o;
        mon_active = 1'b1;
      end else begin
        check("rsp_data_stable", rsp_data_o, mon_data);
        check("rsp_err_stable", rsp_err_o, mon_err);
      end
      if (rsp_ready_i) mon_active = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check({tag, "_cmd_ready"}, cmd_ready_o, 1);
    check({tag, "_rsp_valid"}, rsp_valid_o, 0);
    check({tag, "_rsp_data"}, rsp_data_o, 0);
    check({tag, "_rsp_err"}, rsp_err_o, 0);
    check({tag, "_dreq_bus"},
          {dreq_data_req_o, dreq_address_index_o, dreq_data_be_o, dreq_data_size_o,
           dreq_tag_valid_o, dreq_kill_req_o, dreq_data_we_o}, 0);
    check({tag, "_tag"}, dreq_address_tag_o, 0);
    check({tag, "_wdata"}, dreq_data_wdata_o, 0);
    @(posedge clk); #1;
  endtask

  task automatic issue_cmd(input logic [PW-1:0] paddr, input logic [1:0] size, input logic sgn);
    int n = 0;
    while (!cmd_ready_o && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_wait", cmd_ready_o, 1);
    cmd_valid_i  = 1'b1;
    cmd_paddr_i  = paddr;
    cmd_size_i   = size;
    cmd_signed_i = sgn;
    @(posedge clk); #1;
    cmd_valid_i  = 1'b0;
    cmd_paddr_i  = PW'({$urandom, $urandom});
  endtask

  task automatic req_phase(input logic [PW-1:0] paddr, input logic [1:0] size, input int gnt_delay);
    for (int i = 0; i <= gnt_delay; i++) begin
      dreq_data_gnt_i = (i == gnt_delay);
      @(negedge clk);
      check("req_data_req", dreq_data_req_o, 1);
      check("req_index", dreq_address_index_o, paddr[IW-1:0]);
      check("req_be", dreq_data_be_o, ref_be(paddr[2:0], size));
      check("req_size", dreq_data_size_o, size);
      check("req_tag_valid_low", dreq_tag_valid_o, 0);
      @(posedge clk); #1;
    end
    dreq_data_gnt_i = 1'b0;
  endtask

  task automatic tag_phase(input logic [PW-1:0] paddr, input logic kill, input logic rv,
                           input logic [63:0] rdata);
    tag_cyc            = cyc;
    kill_i             = kill;
    dreq_data_rvalid_i = rv;
    dreq_data_rdata_i  = rdata;
    @(negedge clk);
    check("tag_valid", dreq_tag_valid_o, !kill);
    check("kill_req", dreq_kill_req_o, kill);
    check("tag_addr", dreq_address_tag_o, kill ? '0 : paddr[PW-1:IW]);
    check("tag_data_req_low", dreq_data_req_o, 0);
    @(posedge clk); #1;
    kill_i             = 1'b0;
    dreq_data_rvalid_i = 1'b0;
  endtask

  task automatic pulse_rvalid(input logic [63:0] rdata);
    dreq_data_rvalid_i = 1'b1;
    dreq_data_rdata_i  = rdata;
    @(posedge clk); #1;
    dreq_data_rvalid_i = 1'b0;
    dreq_data_rdata_i  = {$urandom, $urandom};
  endtask

  // k = cycles after the tag cycle at which rvalid arrives; k < 0 means never.
  task automatic do_load(input logic [PW-1:0] paddr, input logic [1:0] size, input logic sgn,
                         input int gnt_delay, input int k, input logic kill, input logic [63:0] rdata);
    logic [63:0] d;
    issue_cmd(paddr, size, sgn);
    req_phase(paddr, size, gnt_delay);
    if (!kill) begin
      if (k >= 0 && k <= T - 1) begin
        d = ref_align(rdata, paddr[2:0], size, sgn);
        exp_q.push_back({d, 1'b0, 16'(k + 1)});
      end else begin
        exp_q.push_back({64'd0, 1'b1, 16'(T)});
      end
    end
    tag_phase(paddr, kill, (k == 0), rdata);
    if (k > 0) begin
      repeat (k - 1) begin
        @(posedge clk); #1;
      end
      pulse_rvalid(rdata);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PW-1:0] pa;
    int            k;
    logic          kl;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_idle_outputs("reset");

    // Basic word load at offset 4
    do_load(56'h80001004, 2'd2, 1'b0, 0, 2, 1'b0, 64'h89ABCDEF_01234567);
    // Signed byte at offset 7, grant delayed 5 cycles
    do_load(56'h80002007, 2'd0, 1'b1, 5, 3, 1'b0, 64'h80112233_44556677);
    // rvalid in the tag cycle with 3 cycles of response backpressure
    bp_hold = 3;
    do_load(56'h12345_0A2, 2'd1, 1'b1, 1, 0, 1'b0, 64'h0123_4567_89AB_CDEF);
    // Kill in the tag cycle; the later ack is discarded
    do_load(56'h55555_100, 2'd3, 1'b0, 0, 3, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
    // Kill with no ack at all
    do_load(56'h55555_108, 2'd2, 1'b0, 2, -1, 1'b1, 64'h0);
    // Timeout: no rvalid ever
    do_load(56'h00ABC_FF8, 2'd3, 1'b0, 0, -1, 1'b0, 64'h0);
    // rvalid on the last wait cycle, then one arriving too late
    do_load(56'h00ABC_FF0, 2'd3, 1'b0, 0, T - 1, 1'b0, 64'hFEDC_BA98_7654_3210);
    do_load(56'h00ABC_FE3, 2'd0, 1'b0, 0, T, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset in the middle of WAIT, stale rvalid, then a clean load
    issue_cmd(56'h77777_010, 2'd2, 1'b1);
    req_phase(56'h77777_010, 2'd2, 0);
    tag_phase(56'h77777_010, 1'b0, 1'b0, 64'h0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check_idle_outputs("rst_mid_wait");
    pulse_rvalid(64'hAAAA_BBBB_CCCC_DDDD);
    check_idle_outputs("stale_rvalid");
    do_load(56'h77777_014, 2'd1, 1'b1, 1, 1, 1'b0, 64'h0000_8001_0000_0000);

    // Randomized loads
    for (int i = 0; i < 60; i++) begin
      pa = PW'({$urandom, $urandom});
      kl = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 5))
        0: k = kl ? 1 : 0;
        1, 2: k = $urandom_range(1, 5);
        3: k = $urandom_range(T - 2, T + 2);
        4: k = -1;
        default: k = $urandom_range(6, T - 3);
      endcase
      if ($urandom_range(0, 7) == 0) bp_hold = $urandom_range(1, 4);
      do_load(pa, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), k,
              kl, {$urandom, $urandom});
    end

    begin
      int n = 0;
      while ((exp_q.size() != 0 || !cmd_ready_o) && n < 400) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_idle", cmd_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
